// File: rtl/apb_fsm_controller.sv
// apb_fsm_controller
//   APB-side initiator of the AHB-to-APB bridge. Takes the decoded AHB
//   request plus its pipelined address/data copies and sequences APB
//   setup/enable phases to three peripherals, stalling the AHB master
//   through HREADYout while a transfer is in flight.
//
// Ports:
//   HCLK, HRESET        clock (rising edge), async active-high reset
//   valid               current AHB address phase targets the APB region
//   HWRITE, HWRITEreg   current direction / direction delayed one cycle
//   HADDR, HADDR_1/2    current address / delayed 1 and 2 cycles
//   HWDATA, HWDATA_1    current write data / delayed 1 cycle
//   PSEL[2:0]           one-hot peripheral select
//   PENABLE, PWRITE     APB enable phase / direction
//   PADDR, PWDATA       APB address / write data
//   HREADYout           0 stalls the AHB master
//   STATE[2:0]          current FSM state
module apb_fsm_controller #(
  parameter int          ADDR_WIDTH = 32,
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] BASE_ADDR  = 32'h4000_0000
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  valid,
  input  logic                  HWRITE,
  input  logic                  HWRITEreg,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [ADDR_WIDTH-1:0] HADDR_1,
  input  logic [ADDR_WIDTH-1:0] HADDR_2,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic [DATA_WIDTH-1:0] HWDATA_1,
  output logic [2:0]            PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  output logic                  HREADYout,
  output logic [2:0]            STATE
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WWAIT    = 3'd1,
    ST_READ     = 3'd2,
    ST_WRITE    = 3'd3,
    ST_WRITEP   = 3'd4,
    ST_RENABLE  = 3'd5,
    ST_WENABLE  = 3'd6,
    ST_WENABLEP = 3'd7
  } state_t;

  state_t                state_q, state_d;
  logic [2:0]            psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  hready_q, hready_d;

  function automatic logic [2:0] decode(input logic [ADDR_WIDTH-1:0] addr);
    logic [2:0] sel;
    sel = '0;
    if (addr[31:16] == BASE_ADDR[31:16]) begin
      case (addr[15:12])
        4'd0:    sel = 3'b001;
        4'd1:    sel = 3'b010;
        4'd2:    sel = 3'b100;
        default: sel = 3'b000;
      endcase
    end
    return sel;
  endfunction

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (valid && HWRITE)       state_d = ST_WWAIT;
        else if (valid)            state_d = ST_READ;
      end
      ST_WWAIT:                    state_d = valid ? ST_WRITEP : ST_WRITE;
      ST_READ:                     state_d = ST_RENABLE;
      ST_WRITE:                    state_d = valid ? ST_WENABLEP : ST_WENABLE;
      ST_WRITEP:                   state_d = ST_WENABLEP;
      ST_RENABLE, ST_WENABLE: begin
        if (valid && !HWRITE)      state_d = ST_READ;
        else if (valid && HWRITE)  state_d = ST_WWAIT;
        else                       state_d = ST_IDLE;
      end
      ST_WENABLEP: begin
        if (!HWRITEreg)            state_d = ST_READ;
        else if (valid)            state_d = ST_WRITEP;
        else                       state_d = ST_WRITE;
      end
      default:                     state_d = ST_IDLE;
    endcase
  end

  // Registered outputs take the values of the state being entered; the
  // source state picks which pipelined address/data copy is loaded.
  always_comb begin
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    hready_d  = hready_q;
    case (state_d)
      ST_IDLE, ST_WWAIT: begin
        psel_d    = '0;
        penable_d = 1'b0;
        hready_d  = 1'b1;
      end
      ST_READ: begin
        paddr_d   = (state_q == ST_WENABLEP) ? HADDR_1 : HADDR;
        psel_d    = decode(paddr_d);
        pwrite_d  = 1'b0;
        penable_d = 1'b0;
        hready_d  = 1'b0;
      end
      ST_WRITE, ST_WRITEP: begin
        if (state_q == ST_WWAIT) begin
          paddr_d  = HADDR_1;
          pwdata_d = HWDATA;
        end else begin
          paddr_d  = HADDR_2;
          pwdata_d = HWDATA_1;
        end
        psel_d    = decode(paddr_d);
        pwrite_d  = 1'b1;
        penable_d = 1'b0;
        hready_d  = (state_d == ST_WRITE);
      end
      ST_RENABLE, ST_WENABLE, ST_WENABLEP: begin
        penable_d = 1'b1;
        hready_d  = (state_d != ST_WENABLEP);
      end
      default: begin
        psel_d    = '0;
        penable_d = 1'b0;
        hready_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q   <= ST_IDLE;
      psel_q    <= '0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      hready_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      hready_q  <= hready_d;
    end
  end

  assign STATE     = state_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign HREADYout = hready_q;

endmodule

// File: doc/apb_fsm_controller.md
Name: apb_fsm_controller

Overview:
- APB-side initiator of the AHB-to-APB bridge.
- Consumes the decoded AHB request and its pipelined address/data copies (valid, HWRITE, HWRITEreg, HADDR_1/2, HWDATA_1) from the AHB slave interface.
- Drives the APB setup/enable phases to the three peripherals.
- Stalls the AHB master through HREADYout while an APB transfer is in flight.

Parameters:
ADDR_WIDTH, 32, address width of HADDR*, PADDR
DATA_WIDTH, 32, width of HWDATA*, PWDATA
BASE_ADDR, 32'h4000_0000, APB region base; bits [31:16] compared for decode

Ports:
HCLK  input  1  bridge clock, rising edge
HRESET  input  1  asynchronous, active-high reset
valid  input  1  current AHB address phase targets APB region
HWRITE  input  1  direction of current AHB address phase
HWRITEreg  input  1  HWRITE delayed one HCLK
HADDR  input  ADDR_WIDTH  current AHB address
HADDR_1  input  ADDR_WIDTH  HADDR delayed 1 cycle
HADDR_2  input  ADDR_WIDTH  HADDR delayed 2 cycles
HWDATA  input  DATA_WIDTH  current AHB write data
HWDATA_1  input  DATA_WIDTH  HWDATA delayed 1 cycle
PSEL  output  3  one-hot peripheral select
PENABLE  output  1  APB enable phase
PWRITE  output  1  APB direction
PADDR  output  ADDR_WIDTH  APB address
PWDATA  output  DATA_WIDTH  APB write data
HREADYout  output  1  0 stalls AHB master
STATE  output  3  current FSM state, for verification

Behaviour:
Reset and register timing:
- Asynchronous reset, active-high on HRESET, effective without a clock edge.
- Reset values: STATE=IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, HREADYout=1.
- All outputs are registered. They update on the same HCLK edge as STATE, with the values defined for the state being entered.
- State encoding: IDLE=0, WWAIT=1, READ=2, WRITE=3, WRITEP=4, RENABLE=5, WENABLE=6, WENABLEP=7.

Decode, applied to the address being loaded into PADDR:
- If addr[31:16] != BASE_ADDR[31:16], PSEL=000.
- Otherwise, by addr[15:12]: 0 gives 001, 1 gives 010, 2 gives 100, any other value gives 000.
- When PSEL=000 the FSM still completes the full transfer sequence. Error reporting is out of scope for this block.

Transitions:
- IDLE: valid&HWRITE -> WWAIT; valid&~HWRITE -> READ; otherwise stay in IDLE.
- WWAIT: valid -> WRITEP; otherwise -> WRITE.
- READ -> RENABLE, unconditionally.
- WRITE: valid -> WENABLEP; otherwise -> WENABLE.
- WRITEP -> WENABLEP, unconditionally.
- RENABLE and WENABLE: valid&~HWRITE -> READ; valid&HWRITE -> WWAIT; otherwise -> IDLE.
- WENABLEP: ~HWRITEreg -> READ; valid&HWRITEreg -> WRITEP; ~valid&HWRITEreg -> WRITE.

Outputs on entry:
- IDLE, WWAIT: PSEL=0, PENABLE=0, HREADYout=1. PADDR, PWDATA and PWRITE hold.
- READ: PADDR=HADDR if entered from IDLE/RENABLE/WENABLE, HADDR_1 if entered from WENABLEP. PSEL=decode(PADDR), PWRITE=0, PENABLE=0, HREADYout=0.
- WRITE or WRITEP from WWAIT: PADDR=HADDR_1, PWDATA=HWDATA.
- WRITE or WRITEP from WENABLEP: PADDR=HADDR_2, PWDATA=HWDATA_1.
- In both WRITE/WRITEP cases: PSEL=decode, PWRITE=1, PENABLE=0. HREADYout=1 for WRITE, 0 for WRITEP.
- RENABLE, WENABLE, WENABLEP: PENABLE=1, hold PSEL/PADDR/PWDATA/PWRITE. HREADYout=1 for RENABLE/WENABLE, 0 for WENABLEP.

Latency and timing rules:
- Every APB transfer is exactly one setup cycle plus one enable cycle. There are no wait states, and PREADY is not supported.
- Write data lags its address by one cycle per AHB. WWAIT exists to capture HWDATA in that lagging cycle.
- PSEL/PADDR/PWRITE/PWDATA are stable across the setup-to-enable boundary.
- PENABLE is never 1 in two consecutive transfers without an intervening setup cycle.

Test Plan:
- Read: IDLE, valid=1, HWRITE=0, HADDR=0x4000_1004 -> edge1 STATE=READ, PSEL=010, PADDR=0x4000_1004, PWRITE=0, PENABLE=0, HREADYout=0 -> edge2 RENABLE, PENABLE=1, HREADYout=1 -> edge3 (valid=0) IDLE, PSEL=0.
- Single write: valid=1, HWRITE=1, HADDR=0x4000_0008; next cycle valid=0, HWDATA=0xDEADBEEF -> WWAIT -> WRITE (PADDR=0x4000_0008, PWDATA=0xDEADBEEF, PSEL=001, PWRITE=1) -> WENABLE (PENABLE=1) -> IDLE.
- Back-to-back writes to 0x4000_2000 then 0x4000_2004 -> WWAIT, WRITEP (HREADYout=0, PADDR=0x4000_2000), WENABLEP, WRITE (PADDR=0x4000_2004 from HADDR_2, PWDATA from HWDATA_1, PSEL=100), WENABLE.
- Write then read: in WENABLEP with HWRITEreg=0, HADDR_1=0x4000_0010 -> READ, PADDR=0x4000_0010, PWRITE=0, PSEL=001.
- Out-of-map read at 0x4000_3000 -> READ/RENABLE sequence still occurs with PSEL=000 throughout.
- Assert HRESET mid-RENABLE, between clock edges -> immediately STATE=0, PSEL=0, PENABLE=0, HREADYout=1. After release, a new read starts cleanly from IDLE.
